// File: rtl/salu_spr_retire_queue_if.sv
// Issue-side and retire-side signals of the SALU SPR retire queue.
// The queue itself connects through the slave modport.
interface salu_spr_retire_queue_if #(
  parameter int WFID_W = 6,
  parameter int DEPTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              issue_salu_valid;
  logic [WFID_W-1:0] issue_salu_wfid;
  logic              issue_salu_vcc_wr;
  logic              issue_salu_scc_wr;
  logic              issue_salu_exec_wr;
  logic              issue_salu_m0_wr;
  logic              issue_salu_ready;
  logic              retire_stall;
  logic [WFID_W-1:0] f_exec_salu_wr_wfid;
  logic              f_exec_salu_wr_vcc_en;
  logic              f_exec_salu_wr_scc_en;
  logic              f_exec_salu_wr_exec_en;
  logic              f_exec_salu_wr_m0_en;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow_err;

  modport master (
    output issue_salu_valid, issue_salu_wfid, issue_salu_vcc_wr, issue_salu_scc_wr,
           issue_salu_exec_wr, issue_salu_m0_wr, retire_stall,
    input  issue_salu_ready, f_exec_salu_wr_wfid, f_exec_salu_wr_vcc_en,
           f_exec_salu_wr_scc_en, f_exec_salu_wr_exec_en, f_exec_salu_wr_m0_en,
           occupancy, overflow_err
  );

  modport slave (
    input  issue_salu_valid, issue_salu_wfid, issue_salu_vcc_wr, issue_salu_scc_wr,
           issue_salu_exec_wr, issue_salu_m0_wr, retire_stall,
    output issue_salu_ready, f_exec_salu_wr_wfid, f_exec_salu_wr_vcc_en,
           f_exec_salu_wr_scc_en, f_exec_salu_wr_exec_en, f_exec_salu_wr_m0_en,
           occupancy, overflow_err
  );
endinterface

// File: rtl/salu_spr_retire_queue.sv
// In-order retire queue for SALU instrs writing VCC/SCC/EXEC/M0; emits one-cycle
// retire pulses that clear SPR busy bits in the issue-stage dependency table.

module salu_spr_retire_queue_entry #(
  parameter int PL_W     = 10,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PL_W-1:0]  push_pl,
  output logic             vld,
  output logic [PL_W-1:0]  pl,
  output logic [CNT_W-1:0] cnt
);
  // Countdown runs whether or not the head is stalled; it saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      pl  <= '0;
      cnt <= '0;
    end else if (push) begin
      vld <= 1'b1;
      pl  <= push_pl;
      cnt <= CNT_W'(CNT_INIT);
    end else begin
      if (pop) vld <= 1'b0;
      if (vld && cnt != '0) cnt <= cnt - 1'b1;
    end
  end
endmodule

module salu_spr_retire_queue #(
  parameter int WFID_W  = 6,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input logic             clk,
  input logic             rst,
  salu_spr_retire_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PL_W  = WFID_W + 4;

  logic [PTR_W-1:0]              head, tail;
  logic [OCC_W-1:0]              occ, occ_nxt;
  logic                          ready_q, ovf_q;
  logic                          any_wr, push, pop;
  logic [PL_W-1:0]               push_pl, rt_pl;
  logic [DEPTH-1:0]              ent_vld, ent_push, ent_pop;
  logic [DEPTH-1:0][PL_W-1:0]    ent_pl;
  logic [DEPTH-1:0][CNT_W-1:0]   ent_cnt;

  assign any_wr  = q.issue_salu_vcc_wr | q.issue_salu_scc_wr |
                   q.issue_salu_exec_wr | q.issue_salu_m0_wr;
  // Flagless issues never enter the queue; they cannot clear anything.
  assign push    = q.issue_salu_valid & any_wr & ready_q;
  assign push_pl = {q.issue_salu_wfid, q.issue_salu_vcc_wr, q.issue_salu_scc_wr,
                    q.issue_salu_exec_wr, q.issue_salu_m0_wr};
  // Only the head may retire, so younger expired entries wait their turn.
  assign pop     = ent_vld[head] && (ent_cnt[head] == '0) && !q.retire_stall;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_push[i] = push && (tail == PTR_W'(i));
    assign ent_pop[i]  = pop  && (head == PTR_W'(i));
    salu_spr_retire_queue_entry #(
      .PL_W(PL_W), .CNT_W(CNT_W), .CNT_INIT(LATENCY - 1)
    ) u_ent (
      .clk    (clk),
      .rst    (rst),
      .push   (ent_push[i]),
      .pop    (ent_pop[i]),
      .push_pl(push_pl),
      .vld    (ent_vld[i]),
      .pl     (ent_pl[i]),
      .cnt    (ent_cnt[i])
    );
  end

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + 1'b1;
    else if (!push && pop) occ_nxt = occ - 1'b1;
  end

  // ready is a flop of the next occupancy, so a full queue refuses even while popping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
      rt_pl   <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      occ     <= occ_nxt;
      ready_q <= occ_nxt < OCC_W'(DEPTH);
      if (q.issue_salu_valid && any_wr && !ready_q) ovf_q <= 1'b1;
      rt_pl   <= pop ? ent_pl[head] : '0;
    end
  end

  assign q.issue_salu_ready       = ready_q;
  assign q.occupancy              = occ;
  assign q.overflow_err           = ovf_q;
  assign q.f_exec_salu_wr_wfid    = rt_pl[PL_W-1:4];
  assign q.f_exec_salu_wr_vcc_en  = rt_pl[3];
  assign q.f_exec_salu_wr_scc_en  = rt_pl[2];
  assign q.f_exec_salu_wr_exec_en = rt_pl[1];
  assign q.f_exec_salu_wr_m0_en   = rt_pl[0];
endmodule

// File: tb/tb_salu_spr_retire_queue.sv
// Directed bench for salu_spr_retire_queue (WFID_W=6, DEPTH=4, LATENCY=3).
// Cycle k means the interval after posedge k; checks are sampled #1 after the edge.
module tb_salu_spr_retire_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errs    = 0;

  salu_spr_retire_queue_if #(.WFID_W(6), .DEPTH(4)) q();

  salu_spr_retire_queue #(.WFID_W(6), .DEPTH(4), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .q(q)
  );

  always #5 clk = ~clk;

  // Retire bundle as {wfid[5:0], vcc, scc, exec, m0}
  function automatic logic [9:0] rt();
    return {q.f_exec_salu_wr_wfid, q.f_exec_salu_wr_vcc_en, q.f_exec_salu_wr_scc_en,
            q.f_exec_salu_wr_exec_en, q.f_exec_salu_wr_m0_en};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags order {vcc, scc, exec, m0}
  task automatic issue(input logic [5:0] wfid, input logic [3:0] flags);
    q.issue_salu_valid   = 1'b1;
    q.issue_salu_wfid    = wfid;
    q.issue_salu_vcc_wr  = flags[3];
    q.issue_salu_scc_wr  = flags[2];
    q.issue_salu_exec_wr = flags[1];
    q.issue_salu_m0_wr   = flags[0];
  endtask

  task automatic idle();
    q.issue_salu_valid   = 1'b0;
    q.issue_salu_wfid    = '0;
    q.issue_salu_vcc_wr  = 1'b0;
    q.issue_salu_scc_wr  = 1'b0;
    q.issue_salu_exec_wr = 1'b0;
    q.issue_salu_m0_wr   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    q.retire_stall = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    idle();
    q.retire_stall = 1'b0;
    do_reset();

    // reset state
    chk("rst_occ",   q.occupancy, 0);
    chk("rst_ready", q.issue_salu_ready, 1);
    chk("rst_rt",    rt(), 0);
    chk("rst_ovf",   q.overflow_err, 0);

    // single scc push at edge 0 -> pulse only in cycle 3
    issue(6'd5, 4'b0100);
    tick(); idle();
    chk("t1_occ_c0", q.occupancy, 1);
    tick(); chk("t1_rt_c1", rt(), 0);
    tick(); chk("t1_rt_c2", rt(), 0);
    tick(); chk("t1_rt_c3", rt(), {6'd5, 4'b0100});
    chk("t1_occ_c3", q.occupancy, 0);
    tick(); chk("t1_rt_c4", rt(), 0);

    // back-to-back 1(vcc) 2(exec) 3(m0), then 4(scc) pushed on the edge 1 pops
    do_reset();
    issue(6'd1, 4'b1000); tick();
    issue(6'd2, 4'b0010); tick();
    chk("t2_rt_c1", rt(), 0);
    issue(6'd3, 4'b0001); tick();
    chk("t2_occ_c2", q.occupancy, 3);
    issue(6'd4, 4'b0100); tick(); idle();
    chk("t2_rt_c3",  rt(), {6'd1, 4'b1000});
    chk("t2_occ_c3", q.occupancy, 3);
    tick(); chk("t2_rt_c4", rt(), {6'd2, 4'b0010});
    tick(); chk("t2_rt_c5", rt(), {6'd3, 4'b0001});
    tick(); chk("t2_rt_c6", rt(), {6'd4, 4'b0100});
    tick(); chk("t2_rt_c7", rt(), 0);
    chk("t2_occ_c7", q.occupancy, 0);

    // multi-flag entry held by stall on edges 2..6 -> single pulse in cycle 7
    do_reset();
    issue(6'd7, 4'b1101); tick(); idle();
    tick(); q.retire_stall = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      tick(); chk($sformatf("t3_rt_c%0d", c), rt(), 0);
    end
    q.retire_stall = 1'b0;
    tick(); chk("t3_rt_c7", rt(), {6'd7, 4'b1101});
    tick(); chk("t3_rt_c8", rt(), 0);

    // fill to DEPTH under stall, overflow a 5th, then drain in order
    do_reset();
    q.retire_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(6'(10 + i), 4'b1000); tick();
    end
    chk("t4_occ_full",   q.occupancy, 4);
    chk("t4_ready_full", q.issue_salu_ready, 0);
    chk("t4_ovf_pre",    q.overflow_err, 0);
    issue(6'd14, 4'b0010); tick(); idle();
    chk("t4_ovf",     q.overflow_err, 1);
    chk("t4_occ_ovf", q.occupancy, 4);
    q.retire_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("t4_rt_%0d", i), rt(), {6'(10 + i), 4'b1000});
      if (i == 0) chk("t4_ready_after_pop", q.issue_salu_ready, 1);
    end
    tick(); chk("t4_rt_none1", rt(), 0);
    tick(); chk("t4_rt_none2", rt(), 0);
    chk("t4_occ_end", q.occupancy, 0);
    chk("t4_ovf_sticky", q.overflow_err, 1);

    // valid with no flags is ignored
    do_reset();
    issue(6'd9, 4'b0000); tick(); idle();
    chk("t5_occ_c0", q.occupancy, 0);
    for (int c = 1; c <= 4; c++) begin
      tick(); chk($sformatf("t5_rt_c%0d", c), rt(), 0);
    end

    // reset asserted mid-flight during cycle 2 discards the entry
    do_reset();
    issue(6'd9, 4'b0100); tick(); idle();
    tick();
    tick(); rst = 1'b0; #1;
    chk("t6_occ_rst", q.occupancy, 0);
    #2 rst = 1'b1;
    for (int c = 3; c <= 6; c++) begin
      tick(); chk($sformatf("t6_rt_c%0d", c), rt(), 0);
    end
    chk("t6_ready", q.issue_salu_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
